// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter driving a shared N:1 word mux and a
// single valid/ready output port. One requester is granted at a time; its
// word is latched into out_data and held until downstream accepts it.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active-high
//   req        per-requester request bits
//   data_in    packed request words, slice i = data_in[i*DATA_W +: DATA_W]
//   ack        one-cycle pulse on the bit of the requester whose word was accepted
//   out_valid  out_data holds a granted word
//   out_data   registered granted word
//   out_ready  downstream accept (handshake when out_valid && out_ready)
//   sel        index of the granted requester (mux select)
//   busy       high while a grant is outstanding
module rr_mux_arbiter #(
    parameter  int unsigned N      = 4,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned SEL_W  = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N*DATA_W-1:0] data_in,
    output logic [N-1:0]        ack,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic [SEL_W-1:0]    sel,
    output logic                busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  ptr_n;
    logic [SEL_W-1:0]  sel_n;
    logic [N-1:0]      ack_n;
    logic              out_valid_n;
    logic [DATA_W-1:0] out_data_n;
    logic              busy_n;

    logic [DATA_W-1:0] words [N];
    logic              found;
    logic [SEL_W-1:0]  winner;
    int unsigned       scan_idx;
    logic [SEL_W-1:0]  scan_sel;

    // Unpack the requester words for the mux.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            words[i] = data_in[i*DATA_W +: DATA_W];
        end
    end

    // Rotating priority search starting at ptr; the first hit wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        scan_sel = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = 32'(ptr) + k;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            scan_sel = SEL_W'(scan_idx);
            if (!found && req[scan_sel]) begin
                found  = 1'b1;
                winner = scan_sel;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        sel_n       = sel;
        ack_n       = '0;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        busy_n      = busy;

        case (state)
            IDLE: begin
                out_valid_n = 1'b0;
                busy_n      = 1'b0;
                if (found) begin
                    out_data_n  = words[winner];
                    sel_n       = winner;
                    out_valid_n = 1'b1;
                    busy_n      = 1'b1;
                    state_n     = GRANT;
                end
            end
            GRANT: begin
                // Word and select are frozen until the handshake; the granted
                // index then becomes lowest priority.
                if (out_ready) begin
                    ack_n[sel]  = 1'b1;
                    ptr_n       = (sel == SEL_W'(N - 1)) ? '0 : sel + SEL_W'(1);
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            ack       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            sel       <= sel_n;
            ack       <= ack_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with a scoreboard: each scenario pushes
// the words it expects to be delivered, and an independent monitor pops and
// compares them at every accepted handshake, then checks the ack pulse.
module tb_rr_mux_arbiter;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [N-1:0]        req;
    logic [N*DATA_W-1:0] data_in;
    logic [N-1:0]        ack;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_ready;
    logic [SEL_W-1:0]    sel;
    logic                busy;

    exp_t         exp_q [$];
    exp_t         exp_item;
    logic [N-1:0] exp_ack;
    int           n_cmp;
    int           n_err;

    rr_mux_arbiter #(.N(N), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int unsigned i, input logic [DATA_W-1:0] v);
        data_in[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic expect_word(input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d);
        exp_t e;
        e.sel  = s;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: at each falling edge, verify the ack that should follow the
    // previous handshake, then score any handshake pending for the next edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_ack = '0;
        end else begin
            check("ack", 32'(ack), 32'(exp_ack));
            exp_ack = '0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got sel=%0d data=%0h, expected no word (t=%0t)",
                             sel, out_data, $time);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("word_sel", 32'(sel), 32'(exp_item.sel));
                    check("word_data", 32'(out_data), 32'(exp_item.data));
                end
                exp_ack = N'(1) << sel;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_ack   = '0;
        reset     = 1'b1;
        req       = '0;
        data_in   = '0;
        out_ready = 1'b0;

        // Reset values
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single requester 2
        set_word(0, 8'h10); set_word(1, 8'h11); set_word(2, 8'hA5); set_word(3, 8'h13);
        req = 4'b0100; out_ready = 1'b1;
        expect_word(2'd2, 8'hA5);
        tick();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        tick();
        req = 4'b0000;
        tick();
        check("single_idle_valid", 32'(out_valid), 32'd0);

        // Pointer wrap: ptr=3 now, grant 3 then 0011 -> 0 then 1
        set_word(3, 8'h33);
        req = 4'b1000;
        expect_word(2'd3, 8'h33);
        tick();
        tick();
        set_word(0, 8'h20); set_word(1, 8'h21);
        req = 4'b0011;
        expect_word(2'd0, 8'h20);
        tick();
        check("wrap_sel0", 32'(sel), 32'd0);
        tick();
        expect_word(2'd1, 8'h21);
        tick();
        check("wrap_sel1", 32'(sel), 32'd1);
        tick();
        req = 4'b0000;
        tick();

        // Backpressure: grant 1 held 5 cycles while its input word changes
        set_word(1, 8'h3C);
        req = 4'b0010; out_ready = 1'b0;
        expect_word(2'd1, 8'h3C);
        tick();
        set_word(1, 8'hFF);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sel", 32'(sel), 32'd1);
            check("bp_data", 32'(out_data), 32'h3C);
            check("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        req = 4'b0000;
        tick();

        // Req drop during grant: requester 2 withdraws while stalled
        set_word(2, 8'h5A);
        req = 4'b0100; out_ready = 1'b0;
        expect_word(2'd2, 8'h5A);
        tick();
        req = 4'b0000;
        tick();
        tick();
        check("drop_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;

        // Reset mid-grant: word dropped, no ack afterwards
        set_word(2, 8'h77);
        req = 4'b0100;
        tick();
        check("mid_valid", 32'(out_valid), 32'd1);
        check("mid_sel", 32'(sel), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        // Full contention from ptr=0: grants 0,1,2,3,0
        set_word(0, 8'hA0); set_word(1, 8'hB1); set_word(2, 8'hC2); set_word(3, 8'hD3);
        expect_word(2'd0, 8'hA0);
        expect_word(2'd1, 8'hB1);
        expect_word(2'd2, 8'hC2);
        expect_word(2'd3, 8'hD3);
        expect_word(2'd0, 8'hA0);
        req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        req = 4'b0000;
        tick();
        tick();
        tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
